prefetch_arbiter: RTL

PREFETCH_ARBITER -- requirements
Module: prefetch_arbiter

---
 rtl/prefetch_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/prefetch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_arbiter
// Brief    : Arbitrates cache demand traffic and next-line prefetches onto one
//            cacheline adapter, with a single-line prefetch buffer.
// Revision : 1.0
// ============================================================================
module prefetch_arbiter #(
    parameter int s_offset = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pf_enable,
    input  logic         dem_read,
    input  logic         dem_write,
    input  logic [31:0]  dem_address,
    input  logic [255:0] dem_wdata,
    output logic [255:0] dem_rdata,
    output logic         dem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  pf_hit_count
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DEM_RD   = 3'd1;
    localparam logic [2:0] ST_DEM_WR   = 3'd2;
    localparam logic [2:0] ST_BUF_HIT  = 3'd3;
    localparam logic [2:0] ST_PREFETCH = 3'd4;

    localparam logic [31:0] LINE_BYTES = 32'd1 << s_offset;
    localparam logic [31:0] LINE_MASK  = ~(LINE_BYTES - 32'd1);
    localparam logic [15:0] HIT_MAX    = 16'hFFFF;

    logic [2:0]   state_q, state_d;
    logic         buf_valid_q, buf_valid_d;
    logic [31:0]  buf_line_q, buf_line_d;
    logic [255:0] buf_data_q, buf_data_d;
    logic         pf_pending_q, pf_pending_d;
    logic [31:0]  pf_addr_q, pf_addr_d;
    logic [31:0]  dem_line_q, dem_line_d;
    logic [15:0]  pf_hit_count_q, pf_hit_count_d;

    logic [31:0]  w_dem_line;
    logic         w_buf_match;
    logic         w_done;
    logic [31:0]  w_done_line;
    logic [31:0]  w_next_line;

    assign w_dem_line  = dem_address & LINE_MASK;
    assign w_buf_match = buf_valid_q && (buf_line_q == w_dem_line);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            buf_valid_q    <= 1'b0;
            buf_line_q     <= 32'd0;
            buf_data_q     <= 256'd0;
            pf_pending_q   <= 1'b0;
            pf_addr_q      <= 32'd0;
            dem_line_q     <= 32'd0;
            pf_hit_count_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            buf_valid_q    <= buf_valid_d;
            buf_line_q     <= buf_line_d;
            buf_data_q     <= buf_data_d;
            pf_pending_q   <= pf_pending_d;
            pf_addr_q      <= pf_addr_d;
            dem_line_q     <= dem_line_d;
            pf_hit_count_q <= pf_hit_count_d;
        end
    end

    // Next-state: writes beat reads, demands beat prefetches, prefetch is non-preemptive
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dem_write) begin
                    state_d = ST_DEM_WR;
                end else if (dem_read) begin
                    state_d = w_buf_match ? ST_BUF_HIT : ST_DEM_RD;
                end else if (pf_pending_q && pf_enable) begin
                    state_d = ST_PREFETCH;
                end
            end
            ST_DEM_RD:   if (pmem_resp) state_d = ST_IDLE;
            ST_DEM_WR:   if (pmem_resp) state_d = ST_IDLE;
            ST_BUF_HIT:  state_d = ST_IDLE;
            ST_PREFETCH: if (pmem_resp) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Buffer, prefetch bookkeeping and hit counter
    always_comb begin
        buf_valid_d    = buf_valid_q;
        buf_line_d     = buf_line_q;
        buf_data_d     = buf_data_q;
        pf_pending_d   = pf_pending_q;
        pf_addr_d      = pf_addr_q;
        dem_line_d     = dem_line_q;
        pf_hit_count_d = pf_hit_count_q;
        w_done         = 1'b0;
        w_done_line    = 32'd0;
        w_next_line    = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (dem_write) begin
                    dem_line_d = w_dem_line;
                    // A written line must never be served stale from the buffer
                    if (buf_line_q == w_dem_line) buf_valid_d  = 1'b0;
                    if (pf_addr_q == w_dem_line)  pf_pending_d = 1'b0;
                end else if (dem_read) begin
                    dem_line_d = w_dem_line;
                end
            end
            ST_DEM_RD: begin
                if (pmem_resp) begin
                    w_done      = 1'b1;
                    w_done_line = dem_line_q;
                end
            end
            ST_BUF_HIT: begin
                w_done      = 1'b1;
                w_done_line = buf_line_q;
                if (pf_hit_count_q != HIT_MAX) pf_hit_count_d = pf_hit_count_q + 16'd1;
            end
            ST_PREFETCH: begin
                if (pmem_resp) begin
                    buf_data_d   = pmem_rdata;
                    buf_line_d   = pf_addr_q;
                    buf_valid_d  = 1'b1;
                    pf_pending_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Next line wraps naturally at the top of the 32-bit space
        w_next_line = w_done_line + LINE_BYTES;
        if (w_done && pf_enable && !(buf_valid_q && (buf_line_q == w_next_line))) begin
            pf_pending_d = 1'b1;
            pf_addr_d    = w_next_line;
        end

        if (!pf_enable) pf_pending_d = 1'b0;
    end

    // Outputs decoded from state; everything idles at zero
    always_comb begin
        dem_rdata    = 256'd0;
        dem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'd0;
        pmem_wdata   = 256'd0;
        case (state_q)
            ST_DEM_RD: begin
                pmem_read    = 1'b1;
                pmem_address = dem_line_q;
                if (pmem_resp) begin
                    dem_resp  = 1'b1;
                    dem_rdata = pmem_rdata;
                end
            end
            ST_DEM_WR: begin
                pmem_write   = 1'b1;
                pmem_address = dem_line_q;
                pmem_wdata   = dem_wdata;
                dem_resp     = pmem_resp;
            end
            ST_BUF_HIT: begin
                dem_resp  = 1'b1;
                dem_rdata = buf_data_q;
            end
            ST_PREFETCH: begin
                pmem_read    = 1'b1;
                pmem_address = pf_addr_q;
            end
            default: ;
        endcase
    end

    assign pf_hit_count = pf_hit_count_q;

endmodule

`default_nettype wire
